// File: rtl/lane_arb_pkg.sv
// Shared constants and the requester-id type for the lane write arbiter.
package lane_arb_pkg;

  localparam int LANE_ARB_WIDTH = 8;
  localparam int LANE_ARB_CNT_W = 8;

  // The round-robin pointer holds the id of the requester favoured on the next conflict.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/lane_write_arbiter_if.sv
// Two-requester lane-write bus. conflict_cnt exists only when LANE_ARB_CONFLICT_CNT_EN is defined.
interface lane_write_arbiter_if
  import lane_arb_pkg::*;
#(
  parameter int WIDTH = LANE_ARB_WIDTH,
  parameter int CNT_W = LANE_ARB_CNT_W
);

  logic             req_a;
  logic [0:WIDTH-1] mask_a;
  logic [0:WIDTH-1] data_a;
  logic             gnt_a;
  logic             req_b;
  logic [0:WIDTH-1] mask_b;
  logic [0:WIDTH-1] data_b;
  logic             gnt_b;
  logic [0:WIDTH-1] aa;
  logic             conflict;

`ifdef LANE_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output req_a, mask_a, data_a, req_b, mask_b, data_b,
    input  gnt_a, gnt_b, aa, conflict, conflict_cnt
  );

  modport slave (
    input  req_a, mask_a, data_a, req_b, mask_b, data_b,
    output gnt_a, gnt_b, aa, conflict, conflict_cnt
  );
`else
  // CNT_W only sizes the optional counter; this keeps the parameter referenced.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  modport master (
    output req_a, mask_a, data_a, req_b, mask_b, data_b,
    input  gnt_a, gnt_b, aa, conflict
  );

  modport slave (
    input  req_a, mask_a, data_a, req_b, mask_b, data_b,
    output gnt_a, gnt_b, aa, conflict
  );
`endif

endinterface

// File: rtl/lane_arb_rr.sv
// Combinational grant decision: overlap detection plus round-robin tie-break.
module lane_arb_rr
  import lane_arb_pkg::*;
#(
  parameter int WIDTH = LANE_ARB_WIDTH
) (
  input  logic             req_a,
  input  logic             req_b,
  input  logic [0:WIDTH-1] mask_a,
  input  logic [0:WIDTH-1] mask_b,
  input  req_id_e          ptr,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             conflict
);

  // An empty mask can never overlap, so zero-mask requests are never conflicts.
  always_comb begin
    conflict = req_a & req_b & (|(mask_a & mask_b));
    gnt_a    = req_a & ~(conflict & (ptr == REQ_B));
    gnt_b    = req_b & ~(conflict & (ptr == REQ_A));
  end

endmodule

// File: rtl/lane_write_arbiter.sv
// Shared lane register with two arbitrated writers. Define LANE_ARB_CONFLICT_CNT_EN for conflict_cnt.
module lane_write_arbiter
  import lane_arb_pkg::*;
#(
  parameter int WIDTH = LANE_ARB_WIDTH,
  parameter int CNT_W = LANE_ARB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  lane_write_arbiter_if.slave  bus
);

  req_id_e          ptr_reg;
  req_id_e          ptr_next;
  logic [0:WIDTH-1] aa_reg;
  logic [0:WIDTH-1] aa_next;
  logic             rr_gnt_a;
  logic             rr_gnt_b;
  logic             conflict;
  logic             gnt_a;
  logic             gnt_b;

  lane_arb_rr #(.WIDTH(WIDTH)) u_rr (
    .req_a    (bus.req_a),
    .req_b    (bus.req_b),
    .mask_a   (bus.mask_a),
    .mask_b   (bus.mask_b),
    .ptr      (ptr_reg),
    .gnt_a    (rr_gnt_a),
    .gnt_b    (rr_gnt_b),
    .conflict (conflict)
  );

  // Grants are suppressed for the whole reset assertion, not just at the edge.
  assign gnt_a = rr_gnt_a & ~rst;
  assign gnt_b = rr_gnt_b & ~rst;

  always_comb begin
    ptr_next = ptr_reg;
    if (conflict) begin
      ptr_next = (ptr_reg == REQ_A) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= REQ_A;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Grants never overlap on a lane, so the A-first priority here never drops a write.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign aa_next[gi] = (gnt_a & bus.mask_a[gi]) ? bus.data_a[gi] :
                         (gnt_b & bus.mask_b[gi]) ? bus.data_b[gi] :
                         aa_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aa_reg <= '0;
    end else begin
      aa_reg <= aa_next;
    end
  end

`ifdef LANE_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (conflict && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bus.conflict_cnt = cnt_reg;
`else
  // CNT_W only sizes the optional counter; this keeps the parameter referenced.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.conflict = conflict;
  assign bus.aa       = aa_reg;

endmodule

// File: doc/lane_write_arbiter.md
LANE_WRITE_ARBITER -- requirements
Module: lane_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of byte-register bit lanes.
REQ-002 SHALL have parameter CNT_W, default 8, conflict counter width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_a, input, 1, requester A write request.
REQ-006 SHALL have port mask_a, input, [0:WIDTH-1], lanes A writes.
REQ-007 SHALL have port data_a, input, [0:WIDTH-1], A write data.
REQ-008 SHALL have port gnt_a, output, 1, A write accepted this cycle.
REQ-009 SHALL have ports req_b, mask_b, data_b and gnt_b, identical to the A ports, for requester B.
REQ-010 SHALL have port aa, output, [0:WIDTH-1], registered shared register; index 0 leftmost.
REQ-011 SHALL have port conflict, output, 1, high when an overlapping request pair is seen this cycle.
REQ-012 SHALL have port conflict_cnt, output, CNT_W, total conflicts; present only with the macro in REQ-026.

Function
REQ-013 SHALL define conflict = req_a & req_b & |(mask_a & mask_b), combinationally.
REQ-014 SHALL, with no conflict, assert gnt_x combinationally for each requesting x in the same cycle.
REQ-015 SHALL, on conflict, grant only the pointer-selected requester; the other sees gnt low.
REQ-016 SHALL keep a 1-bit round-robin pointer ptr: 0 favours A, 1 favours B.
REQ-017 SHALL toggle ptr to the loser only on a conflict cycle; non-conflict cycles leave ptr unchanged.
REQ-018 SHALL load aa[i] at the next posedge after grant with data_x[i] for every lane i where mask_x[i] is set and gnt_x is high; lanes not written hold their value; write latency is one cycle.
REQ-019 SHALL merge simultaneous non-overlapping grants into one update, so each lane has exactly one driver.
REQ-020 SHALL grant a request with an all-zero mask immediately with no aa change; such a request never counts as a conflict.
REQ-021 SHALL require the requester to hold req, mask and data stable until gnt; deassertion before gnt drops the request silently.
REQ-022 SHALL bound a loser's wait at one cycle: a held losing request wins the next conflict.

Reset
REQ-023 SHALL, while rst is high, force aa to all zeros, ptr to 0, and conflict_cnt to 0, independent of clk.
REQ-024 SHALL hold gnt_a and gnt_b low while rst is high; requests pending at reset are lost and must be re-presented.
REQ-025 SHALL resume arbitration on the first posedge after rst falls, with ptr=0 favouring A.

Configuration
REQ-026 SHALL implement conflict_cnt, a saturating counter that increments each conflict cycle and holds at 2^CNT_W-1, only when LANE_ARB_CONFLICT_CNT_EN is defined.
REQ-027 SHALL, without LANE_ARB_CONFLICT_CNT_EN, omit the conflict_cnt port and counter logic, with all other behaviour identical.

Structure
REQ-028 SHALL take the WIDTH and CNT_W default constants and a requester-id enum (REQ_A=0, REQ_B=1), used for ptr, from shared package lane_arb_pkg.
REQ-029 SHALL place the grant decision (conflict detect + ptr select) in a combinational sub-module lane_arb_rr; aa, ptr and the counter stay in the top module.

Verification
REQ-030 SHALL cover: after reset, A req mask=F0 data=A5 and B req mask=0F data=3C in one cycle -> both gnt, aa=AC next cycle, conflict_cnt=0.
REQ-031 SHALL cover: from aa=00, ptr=0, A mask=18 data=FF and B mask=10 data=00 held -> cycle 1 gnt_a, aa=18; cycle 2 gnt_b, aa=08; conflict_cnt=1.
REQ-032 SHALL cover: three back-to-back overlapping pairs, both held -> grants alternate A,B,A; ptr toggles each conflict cycle.
REQ-033 SHALL cover: rst pulsed mid-conflict between posedges -> aa=00, gnts low immediately; the first post-reset conflict is granted to A.
REQ-034 SHALL cover: 300 conflict cycles with CNT_W=8 and the macro defined -> conflict_cnt saturates at FF; without the macro the bench builds with no counter port.
REQ-035 SHALL cover: A req with mask=00 -> gnt_a the same cycle, aa unchanged, no conflict even with B requesting mask=FF.
